// File: rtl/muldiv_pkg.sv
// Shared encodings and state type for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 6;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CALC   = 2'd1;
  localparam logic [1:0] ST_FINISH = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    CALC   = ST_CALC,
    FINISH = ST_FINISH
  } md_state_t;

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic md_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_core_step.sv
// One combinational iteration: shift-add multiply or restoring shift-subtract divide
// on unsigned magnitudes; acc holds the running upper half / partial remainder.
module muldiv_core_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            i_is_div,
  input  logic [XLEN-1:0] i_acc,
  input  logic [XLEN-1:0] i_q,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_acc,
  output logic [XLEN-1:0] o_q
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shift;
  logic [XLEN:0] w_diff;

  always_comb begin
    w_sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : {(XLEN+1){1'b0}});
    w_shift = {i_acc, i_q[XLEN-1]};
    w_diff  = w_shift - {1'b0, i_b};
    o_acc   = w_sum[XLEN:1];
    o_q     = {w_sum[0], i_q[XLEN-1:1]};
    if (i_is_div) begin
      // A borrow out of the trial subtract means restore the shifted remainder.
      if (!w_diff[XLEN]) begin
        o_acc = w_diff[XLEN-1:0];
        o_q   = {i_q[XLEN-2:0], 1'b1};
      end else begin
        o_acc = w_shift[XLEN-1:0];
        o_q   = {i_q[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO; stalls HI/LO reads while busy.
// MULDIV_FAST_MUL_EN: single-cycle multiply (IDLE -> FINISH), divide stays iterative.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wr_val,
  input  logic            rd_req,
  output logic            busy,
  output logic            done,
  output logic            stall,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_t        r_state;
  logic [1:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [XLEN-1:0]  r_acc;
  logic [XLEN-1:0]  r_q;
  logic [XLEN-1:0]  r_b;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_div0;
  logic [XLEN-1:0]  r_hi;
  logic [XLEN-1:0]  r_lo;
  logic             r_done;

  logic            w_signed;
  logic [XLEN-1:0] w_rs_mag;
  logic [XLEN-1:0] w_rt_mag;
  logic [XLEN-1:0] w_step_acc;
  logic [XLEN-1:0] w_step_q;
  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0] w_quo_fix;
  logic [XLEN-1:0] w_rem_fix;

  assign w_signed = md_is_signed(op);
  assign w_rs_mag = (w_signed && rs_val[XLEN-1]) ? (~rs_val + 1'b1) : rs_val;
  assign w_rt_mag = (w_signed && rt_val[XLEN-1]) ? (~rt_val + 1'b1) : rt_val;

  muldiv_core_step #(.XLEN(XLEN)) u_step (
    .i_is_div (md_is_div(r_op)),
    .i_acc    (r_acc),
    .i_q      (r_q),
    .i_b      (r_b),
    .o_acc    (w_step_acc),
    .o_q      (w_step_q)
  );

  // Overflow case (most-negative / -1) falls out naturally: magnitude quotient negates to itself.
  assign w_prod     = {r_acc, r_q};
  assign w_prod_fix = r_neg_q ? (~w_prod + 1'b1) : w_prod;
  assign w_quo_fix  = r_div0 ? {XLEN{1'b1}} : (r_neg_q ? (~r_q + 1'b1) : r_q);
  assign w_rem_fix  = r_neg_r ? (~r_acc + 1'b1) : r_acc;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] w_fast_prod;
  assign w_fast_prod = {{XLEN{1'b0}}, w_rs_mag} * {{XLEN{1'b0}}, w_rt_mag};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= MD_MULT;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_b     <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_div0  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= op;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= md_is_div(op) ? w_rs_mag : w_rt_mag;
            r_b     <= md_is_div(op) ? w_rt_mag : w_rs_mag;
            r_neg_q <= w_signed & (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
            r_neg_r <= w_signed & rs_val[XLEN-1];
            r_div0  <= md_is_div(op) & (rt_val == '0);
            r_state <= CALC;
`ifdef MULDIV_FAST_MUL_EN
            if (!md_is_div(op)) begin
              r_acc   <= w_fast_prod[2*XLEN-1:XLEN];
              r_q     <= w_fast_prod[XLEN-1:0];
              r_state <= FINISH;
            end
`endif
          end
        end
        CALC: begin
          r_acc <= w_step_acc;
          r_q   <= w_step_q;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(XLEN-1)) r_state <= FINISH;
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // mthi/mtlo only land in IDLE; an op result committed at FINISH wins over any earlier write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (r_state == FINISH) begin
      if (md_is_div(r_op)) begin
        r_hi <= w_rem_fix;
        r_lo <= w_quo_fix;
      end else begin
        r_hi <= w_prod_fix[2*XLEN-1:XLEN];
        r_lo <= w_prod_fix[XLEN-1:0];
      end
    end else if (r_state == IDLE) begin
      if (hi_we) r_hi <= wr_val;
      if (lo_we) r_lo <= wr_val;
    end
  end

  assign busy  = (r_state != IDLE);
  assign done  = r_done;
  assign stall = rd_req & busy;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit plus hand-written mid-op sequences.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wr_val;
  logic        rd_req;
  logic        busy;
  logic        done;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .hi_we  (hi_we),
    .lo_we  (lo_we),
    .wr_val (wr_val),
    .rd_req (rd_req),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [1:0] o);
`ifdef MULDIV_FAST_MUL_EN
    return o[1] ? 33 : 1;
`else
    return 33;
`endif
  endfunction

  // Launch at a negedge, then count edges after the start edge until done (bounded).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; rs_val = 32'h0; rt_val = 32'h0;
    lat = 0; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat, bcnt, stall_cnt, done_seen;

  initial begin
    vecs[0]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{MD_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{MD_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF};
    vecs[5]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[6]  = '{MD_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[7]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[8]  = '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[9]  = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};
    vecs[10] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[11] = '{MD_DIV,   32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; rs_val = '0; rt_val = '0;
    hi_we = 1'b0; lo_we = 1'b0; wr_val = '0; rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    @(negedge clk) rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, lat, bcnt);
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_latency", i), lat, exp_lat(vecs[i].op));
      if (i == 0) begin
        chk("v0_busy_cycles", bcnt, exp_lat(vecs[i].op));
        chk("v0_busy_at_done", busy, 0);
        @(posedge clk); #1;
        chk("v0_done_one_pulse", done, 0);
      end
    end

    // mthi/mtlo in IDLE
    @(negedge clk); hi_we = 1'b1; wr_val = 32'hAAAA0000;
    @(negedge clk); hi_we = 1'b0; lo_we = 1'b1; wr_val = 32'h00005555;
    @(negedge clk); lo_we = 1'b0;
    chk("mthi_idle", hi, 32'hAAAA0000);
    chk("mtlo_idle", lo, 32'h00005555);

    // Read request held through a DIVU, with a dropped mthi in the middle.
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; rs_val = 32'd100; rt_val = 32'd7; rd_req = 1'b1;
    chk("stall_idle", stall, 0);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; stall_cnt = 0;
    while (!done && lat < 100) begin
      if (stall) stall_cnt++;
      hi_we  = (lat == 5);
      wr_val = 32'hDEADBEEF;
      @(posedge clk); #1;
      lat++;
    end
    hi_we = 1'b0;
    chk("stall_cycles", stall_cnt, 33);
    chk("stall_at_done", stall, 0);
    chk("midop_mthi_dropped_hi", hi, 32'd2);
    chk("midop_lo", lo, 32'd14);
    rd_req = 1'b0;

    // Same-cycle start and mtlo: write lands, then the result overwrites it.
    @(negedge clk);
    start = 1'b1; op = MD_MULTU; rs_val = 32'd3; rt_val = 32'd4;
    lo_we = 1'b1; wr_val = 32'h77;
    @(posedge clk); #1;
    start = 1'b0; lo_we = 1'b0;
    chk("same_cycle_mtlo", lo, 32'h77);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("same_cycle_result_lo", lo, 32'd12);
    chk("same_cycle_result_hi", hi, 32'd0);

    // Reset ten cycles into a DIVU aborts it with no later done.
    @(negedge clk);
    start = 1'b1; op = MD_DIVU; rs_val = 32'h1234; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    chk("abort_busy", busy, 0);
    @(negedge clk) rst_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_lo_after", lo, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
